// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SPI-mode SD-card responder.
// Command indices, R1 bits, FSM states and block geometry.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RESP,
        ST_NAC,
        ST_TOKEN,
        ST_DATA,
        ST_CRC
    } state_t;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;

    localparam logic [7:0] BYTE_FF    = 8'hFF;
    localparam logic [7:0] DATA_TOKEN = 8'hFE;
    localparam int         BLOCK_BYTES = 512;

endpackage

// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte engine: pin synchronisers, sclk edge detect,
// rx/tx shift registers, rx_valid and tx_load_req strobes.
module spi_slave_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       sclk,
    input  logic       mosi,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic       cs_n,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       tx_load_req
);
    logic [1:0] cs_s;
    logic [1:0] sclk_s;
    logic [1:0] mosi_s;
    logic       sclk_d;
    logic       rise;
    logic       fall;
    logic [2:0] rcnt;
    logic [2:0] fcnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;

    assign cs_n = cs_s[1];
    assign rise = sclk_s[1] & ~sclk_d;
    assign fall = ~sclk_s[1] & sclk_d;

    // bring the async SPI pins into clk and remember last sclk
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_s   <= 2'b11;
            sclk_s <= 2'b00;
            mosi_s <= 2'b00;
            sclk_d <= 1'b0;
        end else begin
            cs_s   <= {cs_s[0], cs};
            sclk_s <= {sclk_s[0], sclk};
            mosi_s <= {mosi_s[0], mosi};
            sclk_d <= sclk_s[1];
        end
    end

    // sample on rising, shift out on falling, reload after 8th fall
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt        <= 3'd0;
            fcnt        <= 3'd0;
            rx_sr       <= 8'h00;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_sr       <= 8'hFF;
            tx_load_req <= 1'b0;
            miso        <= 1'b1;
        end else begin
            rx_valid    <= 1'b0;
            tx_load_req <= 1'b0;
            if (cs_n) begin
                rcnt  <= 3'd0;
                fcnt  <= 3'd0;
                tx_sr <= 8'hFF;
                miso  <= 1'b1;
            end else begin
                if (rise) begin
                    rx_sr <= {rx_sr[6:0], mosi_s[1]};
                    rcnt  <= rcnt + 3'd1;
                    if (rcnt == 3'd7) begin
                        rx_valid <= 1'b1;
                        rx_byte  <= {rx_sr[6:0], mosi_s[1]};
                    end
                end
                if (fall) begin
                    fcnt <= fcnt + 3'd1;
                    if (fcnt == 3'd7) begin
                        tx_sr       <= tx_byte;
                        miso        <= tx_byte[7];
                        tx_load_req <= 1'b1;
                    end else begin
                        tx_sr <= {tx_sr[6:0], 1'b1};
                        miso  <= tx_sr[6];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sd_spi_responder.sv
// Card side of an SPI-mode SD link: init commands plus CMD17
// single-block reads served from an external byte memory.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int          ADDR_W    = 20,
    parameter int          NAC_BYTES = 2,
    parameter logic [31:0] OCR_VALUE = 32'hC0FF8000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic              card_ready_o
);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic        cs_n;
    logic        rx_valid;
    logic        tx_load_req;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    state_t      state;
    logic [5:0]  cmd_idx;
    logic [31:0] arg;
    logic [2:0]  arg_cnt;
    logic [2:0]  rlen;
    logic [39:0] resp;
    logic        is_read;
    logic        idle;
    logic        app_cmd;
    logic        rd_d;
    logic [7:0]  data_q;
    logic [7:0]  cnt;
    logic [8:0]  blk_cnt;
    logic [7:0]  r1;
    logic        unused_arg;

    assign r1         = {7'b0, idle};
    assign unused_arg = ^arg;

    spi_slave_byte u_byte (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs),
        .sclk        (sclk),
        .mosi        (mosi),
        .tx_byte     (tx_byte),
        .miso        (miso),
        .cs_n        (cs_n),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_load_req (tx_load_req)
    );

    // decode frames on rx, pick the next tx byte at each boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tx_byte      <= BYTE_FF;
            cmd_idx      <= 6'd0;
            arg          <= 32'h0;
            arg_cnt      <= 3'd0;
            rlen         <= 3'd0;
            resp         <= 40'h0;
            is_read      <= 1'b0;
            idle         <= 1'b1;
            app_cmd      <= 1'b0;
            card_ready_o <= 1'b0;
            mem_rd_o     <= 1'b0;
            mem_addr_o   <= '0;
            rd_d         <= 1'b0;
            data_q       <= 8'h00;
            cnt          <= 8'd0;
            blk_cnt      <= 9'd0;
        end else if (cs_n) begin
            state    <= ST_IDLE;
            tx_byte  <= BYTE_FF;
            mem_rd_o <= 1'b0;
            rd_d     <= 1'b0;
        end else begin
            mem_rd_o <= 1'b0;
            rd_d     <= mem_rd_o;
            if (rd_d) data_q <= mem_data_i;
            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_byte[7:6] == 2'b01) begin
                            cmd_idx <= rx_byte[5:0];
                            arg_cnt <= 3'd0;
                            state   <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (arg_cnt != 3'd4) begin
                            arg     <= {arg[23:0], rx_byte};
                            arg_cnt <= arg_cnt + 3'd1;
                        end else begin
                            state   <= ST_RESP;
                            tx_byte <= BYTE_FF;
                            is_read <= 1'b0;
                            rlen    <= 3'd1;
                            app_cmd <= (cmd_idx == CMD55);
                            case (cmd_idx)
                                CMD0: begin
                                    resp         <= {R1_IDLE, 32'h0};
                                    idle         <= 1'b1;
                                    card_ready_o <= 1'b0;
                                end
                                CMD8: begin
                                    resp <= {r1, 24'h000001, arg[7:0]};
                                    rlen <= 3'd5;
                                end
                                CMD16, CMD55: resp <= {r1, 32'h0};
                                CMD41: begin
                                    if (app_cmd) begin
                                        resp         <= {R1_READY, 32'h0};
                                        idle         <= 1'b0;
                                        card_ready_o <= 1'b1;
                                    end else begin
                                        resp <= {R1_ILLEGAL | r1, 32'h0};
                                    end
                                end
                                CMD58: begin
                                    resp <= {r1, OCR_VALUE};
                                    rlen <= 3'd5;
                                end
                                CMD17: begin
                                    if (card_ready_o) begin
                                        resp       <= {R1_READY, 32'h0};
                                        is_read    <= 1'b1;
                                        mem_addr_o <= {arg[ADDR_W-10:0], 9'b0};
                                    end else begin
                                        resp <= {R1_ILLEGAL, 32'h0};
                                    end
                                end
                                default: resp <= {R1_ILLEGAL | r1, 32'h0};
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
            if (tx_load_req) begin
                case (state)
                    ST_RESP: begin
                        if (rlen != 3'd0) begin
                            tx_byte <= resp[39:32];
                            resp    <= {resp[31:0], 8'h00};
                            rlen    <= rlen - 3'd1;
                        end else begin
                            tx_byte <= BYTE_FF;
                            cnt     <= 8'd1;
                            state   <= is_read ? ST_NAC : ST_IDLE;
                        end
                    end
                    ST_NAC: begin
                        if (cnt == 8'(NAC_BYTES)) begin
                            tx_byte  <= DATA_TOKEN;
                            mem_rd_o <= 1'b1;
                            state    <= ST_TOKEN;
                        end else begin
                            tx_byte <= BYTE_FF;
                            cnt     <= cnt + 8'd1;
                        end
                    end
                    ST_TOKEN: begin
                        tx_byte    <= data_q;
                        mem_addr_o <= mem_addr_o + ONE;
                        mem_rd_o   <= 1'b1;
                        blk_cnt    <= 9'd0;
                        state      <= ST_DATA;
                    end
                    ST_DATA: begin
                        blk_cnt <= blk_cnt + 9'd1;
                        if (blk_cnt == 9'(BLOCK_BYTES - 1)) begin
                            tx_byte <= BYTE_FF;
                            cnt     <= 8'd0;
                            state   <= ST_CRC;
                        end else begin
                            tx_byte <= data_q;
                            if (blk_cnt < 9'(BLOCK_BYTES - 2)) begin
                                mem_addr_o <= mem_addr_o + ONE;
                                mem_rd_o   <= 1'b1;
                            end
                        end
                    end
                    ST_CRC: begin
                        tx_byte <= BYTE_FF;
                        cnt     <= cnt + 8'd1;
                        if (cnt == 8'd1) state <= ST_IDLE;
                    end
                    default: tx_byte <= BYTE_FF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Scoreboarded bench for sd_spi_responder: an SPI master drives
// command frames, a card model predicts every miso byte.
module tb_sd_spi_responder;
    localparam int ADDR_W    = 20;
    localparam int NAC_BYTES = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cs;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_i;
    logic              card_ready_o;

    always #5 clk = ~clk;

    sd_spi_responder dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .sclk         (sclk),
        .mosi         (mosi),
        .miso         (miso),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .card_ready_o (card_ready_o)
    );

    logic [7:0]        exp_q[$];
    logic [7:0]        got_q[$];
    logic [ADDR_W-1:0] rd_addr_q[$];
    event              got_ev;
    int                n_checks = 0;
    int                n_fail   = 0;
    int                byte_no  = 0;
    bit                m_idle   = 1'b1;
    bit                m_app    = 1'b0;
    bit                m_ready  = 1'b0;
    logic [7:0]        mon_g;
    logic [7:0]        mon_e;
    logic [5:0]        cmds[8] = '{6'd0, 6'd8, 6'd16, 6'd55,
                                   6'd41, 6'd55, 6'd58, 6'd5};

    // memory image: mem[a] = a[7:0], data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_o) begin
            mem_data_i <= mem_addr_o[7:0];
            rd_addr_q.push_back(mem_addr_o);
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // monitor: pop expected miso byte for each byte the master received
    initial begin
        forever begin
            @(got_ev);
            while (got_q.size() > 0) begin
                mon_g = got_q.pop_front();
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL miso_byte%0d: got %h expected none",
                             byte_no, mon_g);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("miso_byte%0d", byte_no), 32'(mon_g),
                          32'(mon_e));
                end
                byte_no++;
            end
        end
    end

    task automatic xfer(input logic [7:0] b, input logic [7:0] e);
        logic [7:0] r;
        exp_q.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            #40 sclk = 1'b1;
            r[i] = miso;
            #40 sclk = 1'b0;
        end
        got_q.push_back(r);
        ->got_ev;
    endtask

    task automatic xfer_bits(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = 1'b1;
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input int abort_at);
        logic [7:0]        rsp[$];
        logic [7:0]        fr[6];
        logic [7:0]        r1;
        logic [31:0]       ocr;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] a;
        bit                blk;
        ocr = 32'hC0FF8000;
        r1  = {7'b0, m_idle};
        blk = 1'b0;
        rd_addr_q.delete();
        case (idx)
            6'd0: begin
                rsp.push_back(8'h01);
                m_idle  = 1'b1;
                m_ready = 1'b0;
            end
            6'd8: begin
                rsp.push_back(r1);
                rsp.push_back(8'h00);
                rsp.push_back(8'h00);
                rsp.push_back(8'h01);
                rsp.push_back(arg[7:0]);
            end
            6'd16, 6'd55: rsp.push_back(r1);
            6'd17: begin
                if (m_ready) begin
                    rsp.push_back(8'h00);
                    blk = 1'b1;
                end else begin
                    rsp.push_back(8'h04);
                end
            end
            6'd41: begin
                if (m_app) begin
                    rsp.push_back(8'h00);
                    m_idle  = 1'b0;
                    m_ready = 1'b1;
                end else begin
                    rsp.push_back(8'h04 | r1);
                end
            end
            6'd58: begin
                rsp.push_back(r1);
                for (int i = 3; i >= 0; i--) rsp.push_back(ocr[8*i +: 8]);
            end
            default: rsp.push_back(8'h04 | r1);
        endcase
        m_app = (idx == 6'd55);
        fr[0] = {2'b01, idx};
        fr[1] = arg[31:24];
        fr[2] = arg[23:16];
        fr[3] = arg[15:8];
        fr[4] = arg[7:0];
        fr[5] = 8'($urandom);
        for (int i = 0; i < 6; i++) xfer(fr[i], 8'hFF);
        xfer(8'hFF, 8'hFF);
        foreach (rsp[i]) xfer(8'hFF, rsp[i]);
        if (blk) begin
            base = {arg[ADDR_W-10:0], 9'b0};
            for (int i = 0; i < NAC_BYTES; i++) xfer(8'hFF, 8'hFF);
            xfer(8'hFF, 8'hFE);
            for (int k = 0; k < 512; k++) begin
                if (k == abort_at) begin
                    xfer_bits(4);
                    cs = 1'b1;
                    repeat (3) @(posedge clk);
                    #1 check("miso_after_cs", 32'(miso), 32'd1);
                    check("abort_first_addr", 32'(rd_addr_q[0]), 32'(base));
                    #300 cs = 1'b0;
                    #300;
                    return;
                end
                a = base + ADDR_W'(k);
                xfer(8'hFF, a[7:0]);
            end
            xfer(8'hFF, 8'hFF);
            xfer(8'hFF, 8'hFF);
            check("rd_count", 32'(rd_addr_q.size()), 32'd512);
            check("first_addr", 32'(rd_addr_q[0]), 32'(base));
            check("last_addr", 32'(rd_addr_q[rd_addr_q.size()-1]),
                  32'(base + ADDR_W'(511)));
        end
        xfer(8'hFF, 8'hFF);
        check($sformatf("card_ready_cmd%0d", idx), 32'(card_ready_o),
              32'(m_ready));
    endtask

    initial begin
        rst  = 1'b1;
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_miso", 32'(miso), 32'd1);
        check("reset_mem_rd", 32'(mem_rd_o), 32'd0);
        check("reset_mem_addr", 32'(mem_addr_o), 32'd0);
        check("reset_card_ready", 32'(card_ready_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #2 cs = 1'b0;
        #100;
        xfer(8'hFF, 8'hFF);
        xfer(8'hFF, 8'hFF);
        send_cmd(6'd17, 32'd3, -1);
        send_cmd(6'd0, 32'h0, -1);
        send_cmd(6'd8, 32'h000001AA, -1);
        send_cmd(6'd8, $urandom, -1);
        send_cmd(6'd5, $urandom, -1);
        send_cmd(6'd41, 32'h40000000, -1);
        send_cmd(6'd16, 32'd512, -1);
        send_cmd(6'd55, 32'h0, -1);
        send_cmd(6'd41, 32'h40000000, -1);
        send_cmd(6'd58, 32'h0, -1);
        send_cmd(6'd5, $urandom, -1);
        send_cmd(6'd41, 32'h40000000, -1);
        send_cmd(6'd17, 32'd3, -1);
        send_cmd(6'd17, 32'($urandom_range(0, 2047)), 100);
        send_cmd(6'd58, 32'h0, -1);
        for (int f = 0; f < 12; f++) begin
            int pick;
            pick = $urandom_range(0, 7);
            repeat ($urandom_range(0, 2)) xfer(8'hFF, 8'hFF);
            if ($urandom_range(0, 3) == 0) begin
                cs = 1'b1;
                #300 cs = 1'b0;
                #300;
            end
            send_cmd(cmds[pick], $urandom, -1);
        end
        #10;
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("got_queue_drained", 32'(got_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD-card responder. It is the card side of the SPI link that the autotest SD master drives.
- Lets the HMAC/hash autotest flow run in simulation, and optionally on a second FPGA, without a physical SD card.
- Decodes SD command frames and answers the init sequence plus single-block reads (CMD17).
- Block data comes from an external byte-wide memory read port, so test-vector images can be preloaded.

Parameters:
- ADDR_W, 20: byte-address width of the backing memory. Block number uses bits ADDR_W-1:9.
- NAC_BYTES, 2: number of 0xFF bytes between the CMD17 R1 and the 0xFE data token. Must be ≥1.
- OCR_VALUE, 32'hC0FF8000: OCR returned by CMD58 (power-up done, SDHC).

Ports:
- clk  in  1  system clock. Must be ≥8x the sclk frequency.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  SPI chip select, active low, asynchronous to clk.
- sclk  in  1  SPI clock, mode 0, asynchronous to clk.
- mosi  in  1  master-to-card data.
- miso  out  1  card-to-master data.
- mem_rd_o  out  1  one-cycle read strobe.
- mem_addr_o  out  ADDR_W  byte address to read.
- mem_data_i  in  8  read data, valid the cycle after mem_rd_o.
- card_ready_o  out  1  high once ACMD41 has completed (card out of idle).

Behaviour:
- Reset: miso=1, mem_rd_o=0, mem_addr_o=0, card_ready_o=0, FSM=IDLE, idle flag=1, app_cmd=0.
- Input sync: cs, sclk, mosi each pass through a 2-flop synchroniser. sclk rising/falling edges are detected from the synchronised value.
- Mode 0 timing:
  - mosi is sampled on each sclk rising edge, MSB first.
  - miso is updated on each sclk falling edge from a tx shift register.
  - The tx register reloads after the 8th falling edge of each byte.
- cs high (synchronised):
  - miso=1, bit counter=0, FSM→IDLE.
  - Any response in progress is abandoned; card_ready_o and the idle flag are kept.
- Default tx byte is 0xFF.
- FSM states: IDLE, CMD, RESP, NAC, TOKEN, DATA, CRC.
- IDLE:
  - A received byte matching 01xxxxxx starts a frame: store cmd index, FSM→CMD.
  - Any other byte is ignored.
- CMD:
  - Collects 4 argument bytes then the CRC byte. The CRC is ignored.
  - FSM→RESP. The first response byte goes out after one 0xFF byte (NCR=1).
- RESP, responses by command:
  - CMD0: R1=0x01. Idle flag set, card_ready_o cleared.
  - CMD8: R7 = 0x01 / idle flag, then 0x00, 0x00, 0x01, arg[7:0].
  - CMD55: R1 = {7'b0, idle}, set app_cmd.
  - CMD41 with app_cmd=1: R1=0x00, clear idle, card_ready_o=1.
  - CMD58: R1 followed by OCR_VALUE, MSB byte first.
  - CMD16: R1 = {7'b0, idle}.
  - CMD17:
    - If card_ready_o=0: R1=0x04, FSM→IDLE.
    - Otherwise R1=0x00, base=arg[ADDR_W-10:0]<<9, FSM→NAC.
  - Any other index, or CMD41 without app_cmd: R1 = 0x04|idle.
  - app_cmd clears after any command other than CMD55.
  - After the last response byte, FSM→IDLE unless the command is CMD17.
- NAC: sends NAC_BYTES bytes of 0xFF, then FSM→TOKEN.
- TOKEN: sends 0xFE, then FSM→DATA.
- DATA:
  - Sends 512 bytes; byte k = mem[base+k].
  - mem_rd_o pulses one clk after each byte-boundary falling edge, for the next byte. The first read is issued during TOKEN.
  - Data is registered one cycle later, well before the next reload.
  - The 9-bit counter wraps 511→0, then FSM→CRC.
- CRC: sends 0xFF, 0xFF, then FSM→IDLE.
- Command bytes arriving while responding are ignored. The bus is half-duplex; the master clocks 0xFF.
- Simultaneous cs rise and byte-boundary edge: cs wins.

Decomposition:
- Package sd_spi_pkg holds:
  - state enum;
  - cmd index constants (CMD0, CMD8, CMD16, CMD17, CMD41, CMD55, CMD58);
  - R1 bit constants;
  - DATA_TOKEN=8'hFE, BLOCK_BYTES=512.
- One sub-module: spi_slave_byte.
  - Contains the synchronisers, edge detect, rx/tx shift registers and bit counter.
  - Outputs rx_valid and tx_load_req pulses.

Test Plan:
- Reset, then CMD0 (40 00 00 00 00 95) → after one 0xFF byte, miso byte 0x01; card_ready_o=0.
- CMD8 with arg 0x000001AA → bytes 01 00 00 01 AA.
- CMD55 then CMD41 → R1 0x01 then 0x00; card_ready_o rises. CMD58 → 00 C0 FF 80 00.
- CMD17 before init → 0x04. After init, CMD17 arg=3 with mem[i]=i[7:0] → 00, FF, FF, FE, then bytes 00..FF twice (addresses 0x600..0x7FF), then FF FF. mem_addr_o starts at 0x600.
- Raise cs mid-DATA at byte 100 → miso=1 within 3 clk, FSM=IDLE; a following CMD58 is answered correctly.
- Unknown CMD5, and CMD41 without preceding CMD55 → R1 0x04 (0x05 while idle).
